hazard_stall_ctrl: RTL and testbench

//  Pipeline hazard controller for the 5-stage F/D/X/M/W core; sits beside the bypass network.

---
 rtl/hazard_stall_ctrl.sv | 147 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use stall, branch flush and mult/div sequencing for the 5-stage F/D/X/M/W core
//
// Ports:
//   i_clock          rising-edge clock
//   i_reset_n        synchronous active-low reset; forces all combinational outputs to 0 while low
//   i_ir_d           instruction held in the D stage
//   i_ir_x           instruction held in the X stage
//   i_branch_taken   X-stage branch/jump resolved taken
//   i_md_ready       mult/div result valid pulse
//   i_md_exception   mult/div exception, qualified by i_md_ready
//   i_md_result      mult/div result, qualified by i_md_ready
//   o_stall_f        hold PC
//   o_stall_fd       hold F/D latch
//   o_stall_dx       hold D/X latch
//   o_nop_fd         load nop into F/D latch
//   o_nop_dx         load nop into D/X latch
//   o_nop_xm         load nop into X/M latch
//   o_md_ctrl_mult   one-cycle multiply start pulse
//   o_md_ctrl_div    one-cycle divide start pulse
//   o_md_busy        mult/div operation in flight (START or WAIT)
//   o_md_result_sel  X/M takes o_md_result_q instead of the ALU output
//   o_md_result_q    captured mult/div result
//   o_md_error_q     captured exception or timeout
//   o_stall_cycles   saturating count of cycles with o_stall_f high
module hazard_stall_ctrl #(
    parameter int TIMEOUT     = 64,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic [31:0]            i_ir_d,
    input  logic [31:0]            i_ir_x,
    input  logic                   i_branch_taken,
    input  logic                   i_md_ready,
    input  logic                   i_md_exception,
    input  logic [31:0]            i_md_result,
    output logic                   o_stall_f,
    output logic                   o_stall_fd,
    output logic                   o_stall_dx,
    output logic                   o_nop_fd,
    output logic                   o_nop_dx,
    output logic                   o_nop_xm,
    output logic                   o_md_ctrl_mult,
    output logic                   o_md_ctrl_div,
    output logic                   o_md_busy,
    output logic                   o_md_result_sel,
    output logic [31:0]            o_md_result_q,
    output logic                   o_md_error_q,
    output logic [STALL_CNT_W-1:0] o_stall_cycles
);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [4:0] OP_ALU = 5'b00000;
    localparam logic [4:0] OP_BNE = 5'b00010;
    localparam logic [4:0] OP_JR  = 5'b00100;
    localparam logic [4:0] OP_BLT = 5'b00110;
    localparam logic [4:0] OP_LW  = 5'b01000;
    localparam logic [4:0] AL_MUL = 5'b00110;
    localparam logic [4:0] AL_DIV = 5'b00111;

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t                 r_state;
    logic                   r_op_div;
    logic [TW-1:0]          r_tcnt;
    logic [31:0]            r_md_result_q;
    logic                   r_md_error_q;
    logic [STALL_CNT_W-1:0] r_stall_cycles;

    logic [4:0] w_x_op, w_x_rd, w_d_op, w_d_rd, w_d_rs, w_d_rt;
    logic       w_x_mul, w_x_div, w_x_lw, w_lu_hit, w_md, w_flush, w_lu, w_unused;

    assign w_x_op  = i_ir_x[31:27];
    assign w_x_rd  = i_ir_x[26:22];
    assign w_d_op  = i_ir_d[31:27];
    assign w_d_rd  = i_ir_d[26:22];
    assign w_d_rs  = i_ir_d[21:17];
    assign w_d_rt  = i_ir_d[16:12];
    assign w_x_mul = w_x_op == OP_ALU && i_ir_x[6:2] == AL_MUL;
    assign w_x_div = w_x_op == OP_ALU && i_ir_x[6:2] == AL_DIV;
    assign w_x_lw  = w_x_op == OP_LW;
    assign w_unused = ^{i_ir_x[21:7], i_ir_x[1:0], i_ir_d[11:0]};

    // rt is a source only for R-type; rd is a source for compare/jump-register ops.
    // A store's data register (rd) is covered by the W->M forward, so it is not checked.
    assign w_lu_hit = w_x_lw && w_x_rd != 5'd0 &&
                      (w_x_rd == w_d_rs ||
                       (w_d_op == OP_ALU && w_x_rd == w_d_rt) ||
                       ((w_d_op == OP_BNE || w_d_op == OP_BLT || w_d_op == OP_JR) && w_x_rd == w_d_rd));

    // Priority: mult/div stall, then branch flush, then load-use.
    assign w_md    = i_reset_n && (r_state == START || r_state == WAIT);
    assign w_flush = i_reset_n && !w_md && r_state == IDLE && i_branch_taken;
    assign w_lu    = i_reset_n && !w_md && !w_flush && w_lu_hit;

    assign o_stall_f       = w_md || w_lu;
    assign o_stall_fd      = w_md || w_lu;
    assign o_stall_dx      = w_md;
    assign o_nop_fd        = w_flush;
    assign o_nop_dx        = w_flush || w_lu;
    assign o_nop_xm        = w_md;
    assign o_md_ctrl_mult  = i_reset_n && r_state == START && !r_op_div;
    assign o_md_ctrl_div   = i_reset_n && r_state == START && r_op_div;
    assign o_md_busy       = w_md;
    assign o_md_result_sel = i_reset_n && r_state == DONE;
    assign o_md_result_q   = r_md_result_q;
    assign o_md_error_q    = r_md_error_q;
    assign o_stall_cycles  = r_stall_cycles;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state        <= IDLE;
            r_op_div       <= 1'b0;
            r_tcnt         <= '0;
            r_md_result_q  <= '0;
            r_md_error_q   <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            if (o_stall_f && !(&r_stall_cycles))
                r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
            case (r_state)
                IDLE: begin
                    if (w_x_mul || w_x_div) begin
                        r_op_div <= w_x_div;
                        r_state  <= START;
                    end
                end
                START, WAIT: begin
                    r_tcnt <= (r_state == START) ? '0 : r_tcnt + TW'(1);
                    // A ready pulse arriving already in START is accepted like one in WAIT.
                    if (i_md_ready) begin
                        r_md_result_q <= i_md_result;
                        r_md_error_q  <= i_md_exception;
                        r_state       <= DONE;
                    end else if (r_state == WAIT && r_tcnt == TW'(TIMEOUT - 1)) begin
                        r_md_result_q <= '0;
                        r_md_error_q  <= 1'b1;
                        r_state       <= DONE;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed checks of stall, flush and mult/div sequencing
module tb_hazard_stall_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ir_d, ir_x, md_result, result_q;
    logic        branch_taken, md_ready, md_exception;
    logic        stall_f, stall_fd, stall_dx, nop_fd, nop_dx, nop_xm;
    logic        ctrl_mult, ctrl_div, busy, result_sel, error_q;
    logic [2:0]  stall_cycles;
    int          checks = 0;
    int          errors = 0;
    int          exp_sc = 0;

    localparam logic [9:0] NONE = 10'b0000000000;
    localparam logic [9:0] LU   = 10'b1100100000;
    localparam logic [9:0] FL   = 10'b0001100000;
    localparam logic [9:0] STM  = 10'b1110011010;
    localparam logic [9:0] STD  = 10'b1110010110;
    localparam logic [9:0] WT   = 10'b1110010010;
    localparam logic [9:0] DN   = 10'b0000000001;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.TIMEOUT(8), .STALL_CNT_W(3)) dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_ir_d(ir_d), .i_ir_x(ir_x),
        .i_branch_taken(branch_taken), .i_md_ready(md_ready), .i_md_exception(md_exception),
        .i_md_result(md_result), .o_stall_f(stall_f), .o_stall_fd(stall_fd), .o_stall_dx(stall_dx),
        .o_nop_fd(nop_fd), .o_nop_dx(nop_dx), .o_nop_xm(nop_xm), .o_md_ctrl_mult(ctrl_mult),
        .o_md_ctrl_div(ctrl_div), .o_md_busy(busy), .o_md_result_sel(result_sel),
        .o_md_result_q(result_q), .o_md_error_q(error_q), .o_stall_cycles(stall_cycles)
    );

    function automatic logic [31:0] mk(input logic [4:0] op, rd, rs, rt, aluop);
        return {op, rd, rs, rt, 5'd0, aluop, 2'b00};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, check the combinational outputs mid-cycle, clock it,
    // then check the stall counter against the bench's own saturating count.
    task automatic vec(input string tag, input logic rn, input logic [31:0] x, d,
                       input logic bt, rdy, exc, input logic [31:0] res, input logic [9:0] exp);
        rst_n = rn; ir_x = x; ir_d = d; branch_taken = bt;
        md_ready = rdy; md_exception = exc; md_result = res;
        #1;
        check(tag, {22'd0, stall_f, stall_fd, stall_dx, nop_fd, nop_dx, nop_xm,
                    ctrl_mult, ctrl_div, busy, result_sel}, {22'd0, exp});
        @(posedge clk);
        if (!rn) exp_sc = 0;
        else if (exp[9] && exp_sc < 7) exp_sc++;
        #1;
        check({tag, "_cyc"}, {29'd0, stall_cycles}, exp_sc);
    endtask

    logic [31:0] lw5, add_rs5, add_rt5, addi_rt5, lw0, add_rs0, sw_d5, sw_b5, bne5, mul, dv, nop;

    initial begin
        lw5      = mk(5'b01000, 5'd5, 5'd1, 5'd0, 5'd0);
        add_rs5  = mk(5'b00000, 5'd6, 5'd5, 5'd2, 5'd0);
        add_rt5  = mk(5'b00000, 5'd6, 5'd2, 5'd5, 5'd0);
        addi_rt5 = mk(5'b00101, 5'd6, 5'd2, 5'd5, 5'd0);
        lw0      = mk(5'b01000, 5'd0, 5'd1, 5'd0, 5'd0);
        add_rs0  = mk(5'b00000, 5'd6, 5'd0, 5'd2, 5'd0);
        sw_d5    = mk(5'b00111, 5'd5, 5'd3, 5'd0, 5'd0);
        sw_b5    = mk(5'b00111, 5'd4, 5'd5, 5'd0, 5'd0);
        bne5     = mk(5'b00010, 5'd5, 5'd1, 5'd0, 5'd0);
        mul      = mk(5'b00000, 5'd3, 5'd1, 5'd2, 5'b00110);
        dv       = mk(5'b00000, 5'd3, 5'd1, 5'd2, 5'b00111);
        nop      = 32'h0;
        vec("rst", 1'b0, lw5, add_rs5, 1'b1, 1'b0, 1'b0, 32'h0, NONE);
        check("rst_res", result_q, 32'h0);
        check("rst_err", {31'd0, error_q}, 32'h0);
        vec("lu_rs", 1'b1, lw5, add_rs5, 1'b0, 1'b0, 1'b0, 32'h0, LU);
        vec("lu_after", 1'b1, nop, add_rs5, 1'b0, 1'b0, 1'b0, 32'h0, NONE);
        vec("lu_rt", 1'b1, lw5, add_rt5, 1'b0, 1'b0, 1'b0, 32'h0, LU);
        vec("lu_itype_rt", 1'b1, lw5, addi_rt5, 1'b0, 1'b0, 1'b0, 32'h0, NONE);
        vec("lu_r0", 1'b1, lw0, add_rs0, 1'b0, 1'b0, 1'b0, 32'h0, NONE);
        vec("sw_data", 1'b1, lw5, sw_d5, 1'b0, 1'b0, 1'b0, 32'h0, NONE);
        vec("sw_base", 1'b1, lw5, sw_b5, 1'b0, 1'b0, 1'b0, 32'h0, LU);
        vec("bne_rd", 1'b1, lw5, bne5, 1'b0, 1'b0, 1'b0, 32'h0, LU);
        vec("flush", 1'b1, lw5, add_rs5, 1'b1, 1'b0, 1'b0, 32'h0, FL);
        vec("mul_idle", 1'b1, mul, nop, 1'b0, 1'b0, 1'b0, 32'h0, NONE);
        vec("mul_start", 1'b1, mul, nop, 1'b1, 1'b0, 1'b0, 32'h0, STM);
        vec("mul_w1", 1'b1, mul, add_rs5, 1'b0, 1'b0, 1'b0, 32'h0, WT);
        vec("mul_w2", 1'b1, mul, nop, 1'b0, 1'b0, 1'b0, 32'h0, WT);
        vec("mul_w3", 1'b1, mul, nop, 1'b0, 1'b1, 1'b0, 32'h12345678, WT);
        check("mul_res", result_q, 32'h12345678);
        check("mul_err", {31'd0, error_q}, 32'h0);
        vec("mul_done", 1'b1, mul, nop, 1'b0, 1'b0, 1'b0, 32'h0, DN);
        vec("div_idle", 1'b1, dv, nop, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, NONE);
        check("idle_rdy_ign", result_q, 32'h12345678);
        vec("div_start", 1'b1, dv, nop, 1'b0, 1'b0, 1'b0, 32'h0, STD);
        for (int i = 0; i < 8; i++)
            vec("div_wait", 1'b1, dv, nop, 1'b0, 1'b0, 1'b0, 32'h0, WT);
        check("to_res", result_q, 32'h0);
        check("to_err", {31'd0, error_q}, 32'h1);
        vec("div_done", 1'b1, dv, nop, 1'b0, 1'b0, 1'b0, 32'h0, DN);
        vec("post_done", 1'b1, nop, nop, 1'b0, 1'b0, 1'b0, 32'h0, NONE);
        vec("m2_idle", 1'b1, mul, nop, 1'b0, 1'b0, 1'b0, 32'h0, NONE);
        vec("m2_start", 1'b1, mul, nop, 1'b0, 1'b0, 1'b0, 32'h0, STM);
        vec("m2_w1", 1'b1, mul, nop, 1'b0, 1'b0, 1'b0, 32'h0, WT);
        vec("m2_rst", 1'b0, mul, nop, 1'b0, 1'b0, 1'b0, 32'h0, NONE);
        check("m2_rst_res", result_q, 32'h0);
        check("m2_rst_err", {31'd0, error_q}, 32'h0);
        vec("late_rdy", 1'b1, nop, nop, 1'b0, 1'b1, 1'b1, 32'h55, NONE);
        check("late_res", result_q, 32'h0);
        check("late_err", {31'd0, error_q}, 32'h0);
        vec("idle_end", 1'b1, nop, nop, 1'b0, 1'b0, 1'b0, 32'h0, NONE);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
